// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants for the register-file operation sequencer: command
//   opcodes, register-file function-select codes, register addresses and the
//   sequencer state encoding.
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam logic [2:0] OP_CLR = 3'd0;
   localparam logic [2:0] OP_LDI = 3'd1;
   localparam logic [2:0] OP_INC = 3'd2;
   localparam logic [2:0] OP_DEC = 3'd3;
   localparam logic [2:0] OP_MOV = 3'd4;
   localparam logic [2:0] OP_SWP = 3'd5;

   localparam logic [2:0] FUN_DEC  = 3'b000;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_CLR  = 3'b011;
   localparam logic [2:0] FUN_HOLD = 3'b100;

   localparam logic [2:0] ADDR_R1 = 3'd0;
   localparam logic [2:0] ADDR_R2 = 3'd1;
   localparam logic [2:0] ADDR_R3 = 3'd2;
   localparam logic [2:0] ADDR_R4 = 3'd3;
   localparam logic [2:0] ADDR_S1 = 3'd4;
   localparam logic [2:0] ADDR_S2 = 3'd5;
   localparam logic [2:0] ADDR_S3 = 3'd6;
   localparam logic [2:0] ADDR_S4 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_REJ  = 2'd3
   } seq_state_t;

   // Opcodes 6/7 are undefined; a swap that names the temporary register as
   // an operand would overwrite its own operand mid-sequence.
   function automatic logic cmd_illegal(input logic [2:0] op,
                                        input logic [2:0] dst,
                                        input logic [2:0] src,
                                        input logic [2:0] tmp);
      return (op > OP_SWP) ||
             ((op == OP_SWP) && ((dst == tmp) || (src == tmp)));
   endfunction

   function automatic logic cmd_reads(input logic [2:0] op);
      return (op == OP_MOV) || (op == OP_SWP);
   endfunction

endpackage

// File: rtl/regsel_decode.sv
// ----------------------------------------------------------------------------
// regsel_decode
//   Turns a 3-bit register address plus write enable into the register
//   file's two active-low enable nibbles. At most one bit of the combined
//   byte is low; none when we=0.
// Ports
//   addr     in  3   0-3 = R1-R4, 4-7 = S1-S4
//   we       in  1   write this cycle
//   reg_sel  out 4   bit3 = R1 .. bit0 = R4, active low
//   scr_sel  out 4   bit3 = S1 .. bit0 = S4, active low
// ----------------------------------------------------------------------------
module regsel_decode
   import regfile_pkg::*;
(
   input  logic [2:0] addr,
   input  logic       we,
   output logic [3:0] reg_sel,
   output logic [3:0] scr_sel
);

   logic [1:0] bit_idx;

   // Address 0 of each bank sits on bit 3 of its nibble.
   assign bit_idx = 2'd3 - addr[1:0];

   always_comb begin
      reg_sel = 4'b1111;
      scr_sel = 4'b1111;
      if (we) begin
         if (addr >= ADDR_S1) begin
            scr_sel[bit_idx] = 1'b0;
         end else begin
            reg_sel[bit_idx] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_op_sequencer.sv
// ----------------------------------------------------------------------------
// regfile_op_sequencer
//   Accepts one register-file command at a time (CLR/LDI/INC/DEC/MOV/SWP)
//   over a valid/ready handshake and sequences the file's function select,
//   write enables and read-port address, hiding the read latency.
//
//   state | meaning
//   IDLE  | ready for a command; Done/Err pulse here after retirement
//   RD    | OutASel = phase source, waiting RD_LAT cycles for OutA
//   WR    | exactly one destination enable low for one cycle
//   REJ   | illegal command, one cycle, no enable, then Done+Err
//
// Parameters
//   DATA_W    data width
//   RD_LAT    register-file read latency, 1..3
//   SWAP_TMP  address used as the swap temporary
// Ports
//   Clock, Reset            clock; synchronous active-high reset
//   CmdValid/CmdReady       command handshake
//   CmdOp/CmdDst/CmdSrc     opcode and operand addresses
//   CmdData                 LDI immediate
//   Done/Err/Busy           retirement pulse, reject pulse, non-idle flag
//   RF_OutA                 register-file read port A data
//   RF_I, RF_FunSel         register-file write data and function
//   RF_RegSel, RF_ScrSel    active-low enables
//   RF_OutASel, RF_OutBSel  read-port addresses (B shows latched Dst)
//   OpCount                 retired legal commands, only with
//                           REGSEQ_OPCOUNT_EN defined
// ----------------------------------------------------------------------------
module regfile_op_sequencer
   import regfile_pkg::*;
#(
   parameter int         DATA_W   = 16,
   parameter int         RD_LAT   = 1,
   parameter logic [2:0] SWAP_TMP = ADDR_S4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              CmdValid,
   output logic              CmdReady,
   input  logic [2:0]        CmdOp,
   input  logic [2:0]        CmdDst,
   input  logic [2:0]        CmdSrc,
   input  logic [DATA_W-1:0] CmdData,
   output logic              Done,
   output logic              Err,
   output logic              Busy,
   input  logic [DATA_W-1:0] RF_OutA,
   output logic [DATA_W-1:0] RF_I,
   output logic [2:0]        RF_FunSel,
   output logic [3:0]        RF_RegSel,
   output logic [3:0]        RF_ScrSel,
   output logic [2:0]        RF_OutASel,
   output logic [2:0]        RF_OutBSel
`ifdef REGSEQ_OPCOUNT_EN
   ,
   output logic [15:0]       OpCount
`endif
);

   localparam logic [1:0] RD_LOAD = 2'(RD_LAT - 1);

   seq_state_t        state_q, state_d;
   logic [2:0]        op_q, dst_q, src_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        phase_q;
   logic [1:0]        rd_cnt_q;
   logic              done_q, err_q;

   logic [2:0]        rd_addr, wr_addr;
   logic              wr_en;

   // state register and command/phase/timer bookkeeping
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_CLR;
         dst_q    <= ADDR_R1;
         src_q    <= ADDR_R1;
         data_q   <= '0;
         phase_q  <= 2'd0;
         rd_cnt_q <= 2'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (CmdValid) begin
                  op_q     <= CmdOp;
                  dst_q    <= CmdDst;
                  src_q    <= CmdSrc;
                  data_q   <= CmdData;
                  phase_q  <= 2'd0;
                  rd_cnt_q <= RD_LOAD;
               end
            end
            ST_RD: begin
               if (rd_cnt_q != 2'd0) begin
                  rd_cnt_q <= rd_cnt_q - 2'd1;
               end
            end
            ST_WR: begin
               if (state_d == ST_RD) begin
                  phase_q  <= phase_q + 2'd1;
                  rd_cnt_q <= RD_LOAD;
               end else begin
                  done_q <= 1'b1;
               end
            end
            ST_REJ: begin
               done_q <= 1'b1;
               err_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (CmdValid) begin
               if (cmd_illegal(CmdOp, CmdDst, CmdSrc, SWAP_TMP)) begin
                  state_d = ST_REJ;
               end else if (cmd_reads(CmdOp)) begin
                  state_d = ST_RD;
               end else begin
                  state_d = ST_WR;
               end
            end
         end
         ST_RD: begin
            if (rd_cnt_q == 2'd0) begin
               state_d = ST_WR;
            end
         end
         ST_WR: begin
            if ((op_q == OP_SWP) && (phase_q != 2'd2)) begin
               state_d = ST_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REJ:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // outputs; swap phases: 0 TMP<-Dst, 1 Dst<-Src, 2 Src<-TMP
   always_comb begin
      CmdReady   = (state_q == ST_IDLE);
      Busy       = (state_q != ST_IDLE);
      Done       = done_q;
      Err        = err_q;
      rd_addr    = src_q;
      wr_addr    = dst_q;
      if (op_q == OP_SWP) begin
         case (phase_q)
            2'd0: begin
               rd_addr = dst_q;
               wr_addr = SWAP_TMP;
            end
            2'd1: begin
               rd_addr = src_q;
               wr_addr = dst_q;
            end
            default: begin
               rd_addr = SWAP_TMP;
               wr_addr = src_q;
            end
         endcase
      end
      RF_OutASel = rd_addr;
      RF_OutBSel = dst_q;
      wr_en      = (state_q == ST_WR);
      RF_FunSel  = FUN_HOLD;
      RF_I       = '0;
      if (wr_en) begin
         case (op_q)
            OP_CLR: RF_FunSel = FUN_CLR;
            OP_LDI: begin
               RF_FunSel = FUN_LOAD;
               RF_I      = data_q;
            end
            OP_INC: RF_FunSel = FUN_INC;
            OP_DEC: RF_FunSel = FUN_DEC;
            default: begin
               RF_FunSel = FUN_LOAD;
               RF_I      = RF_OutA;
            end
         endcase
      end
   end

   regsel_decode u_regsel_decode (
      .addr    (wr_addr),
      .we      (wr_en),
      .reg_sel (RF_RegSel),
      .scr_sel (RF_ScrSel)
   );

`ifdef REGSEQ_OPCOUNT_EN
   logic [15:0] op_count_q;

   // counts exactly the cycles that set Done without Err
   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_count_q <= 16'd0;
      end else if ((state_q == ST_WR) && (state_d == ST_IDLE)) begin
         op_count_q <= op_count_q + 16'd1;
      end
   end

   assign OpCount = op_count_q;
`endif

endmodule
